sevenseg_readback: RTL and testbench

//  Receive-side counterpart of the multiplexed 7-segment driver: samples the scanned
//  an/seg bus and reconstructs the four displayed hex digits. Each digit commits only

---
 rtl/sevenseg_pkg.sv | 56 +++++
 rtl/sevenseg_pattern_decode.sv | 41 ++++
 rtl/sevenseg_readback.sv | 123 ++++++++++++
 tb/tb_sevenseg_readback.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants, glyph table and anode classification for the 7-seg readback
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  // Polarity of the scanned bus: both anodes and segments are active-low
  localparam logic AN_ON  = 1'b0;
  localparam logic SEG_ON = 1'b0;
  localparam logic [3:0] AN_IDLE   = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs as driven on seg[6:0] (seg[0]=a ... seg[6]=g, active-low)
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic [1:0] {
    AN_CLASS_IDLE  = 2'd0,
    AN_CLASS_ONE   = 2'd1,
    AN_CLASS_MULTI = 2'd2
  } an_class_t;

  // Number of digits currently selected
  function automatic logic [2:0] count_low(input logic [3:0] a);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[i] == AN_ON) c = c + 3'd1;
    end
    return c;
  endfunction

  function automatic an_class_t classify_an(input logic [3:0] a);
    an_class_t cls;
    case (count_low(a))
      3'd0:    cls = AN_CLASS_IDLE;
      3'd1:    cls = AN_CLASS_ONE;
      default: cls = AN_CLASS_MULTI;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// rtl/sevenseg_pattern_decode.sv - combinational segment pattern to hex nibble decoder
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       known,
  output logic       blank,
  output logic [3:0] nibble
);

  // Map a glyph to its nibble; anything not in the table reports nibble 0
  always_comb begin
    known  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (seg)
      GLYPH_0:   nibble = 4'h0;
      GLYPH_1:   nibble = 4'h1;
      GLYPH_2:   nibble = 4'h2;
      GLYPH_3:   nibble = 4'h3;
      GLYPH_4:   nibble = 4'h4;
      GLYPH_5:   nibble = 4'h5;
      GLYPH_6:   nibble = 4'h6;
      GLYPH_7:   nibble = 4'h7;
      GLYPH_8:   nibble = 4'h8;
      GLYPH_9:   nibble = 4'h9;
      GLYPH_A:   nibble = 4'hA;
      GLYPH_B:   nibble = 4'hB;
      GLYPH_C:   nibble = 4'hC;
      GLYPH_D:   nibble = 4'hD;
      GLYPH_E:   nibble = 4'hE;
      GLYPH_F:   nibble = 4'hF;
      SEG_BLANK: begin
        known = 1'b0;
        blank = 1'b1;
      end
      default:   known = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_readback.sv
// rtl/sevenseg_readback.sv - reconstructs four hex digits from a scanned active-low an/seg bus
module sevenseg_readback
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic [3:0]  bad_pattern,
  output logic        frame_valid,
  output logic [15:0] value,
  output logic        multi_an,
  output logic        stale
);

  localparam int DW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  logic [3:0]    an_q, an_p;
  logic [6:0]    seg_q, seg_p;
  logic          sample_vld;
  logic [DW-1:0] dwell_q, dwell_nxt;
  logic [TW-1:0] tmo_q;
  an_class_t     an_cls;
  logic [1:0]    digit_idx;
  logic          commit;
  logic          dec_known, dec_blank;
  logic [3:0]    dec_nibble;

  sevenseg_pattern_decode u_decode (
    .seg    (seg_q),
    .known  (dec_known),
    .blank  (dec_blank),
    .nibble (dec_nibble)
  );

  // Register the raw bus and keep the previous sample for the stability compare
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q       <= 4'h0;
      seg_q      <= 7'h00;
      an_p       <= 4'h0;
      seg_p      <= 7'h00;
      sample_vld <= 1'b0;
    end else begin
      an_q       <= an;
      seg_q      <= seg;
      an_p       <= an_q;
      seg_p      <= seg_q;
      sample_vld <= 1'b1;
    end
  end

  // Classify the sample and advance the dwell; a zero dwell means the prior sample is not comparable
  always_comb begin
    an_cls    = sample_vld ? classify_an(an_q) : AN_CLASS_IDLE;
    digit_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_q[i] == AN_ON) digit_idx = 2'(i);
    end
    dwell_nxt = '0;
    if (an_cls == AN_CLASS_ONE) begin
      if (dwell_q != '0 && an_q == an_p && seg_q == seg_p)
        dwell_nxt = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DW'(1);
      else
        dwell_nxt = DW'(1);
    end
    commit = (an_cls == AN_CLASS_ONE) && (dwell_nxt == DWELL_MAX) && (dwell_q != DWELL_MAX);
  end

  // Dwell and timeout counters plus the anode glitch pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q  <= '0;
      tmo_q    <= '0;
      multi_an <= 1'b0;
    end else begin
      dwell_q  <= dwell_nxt;
      multi_an <= (an_cls == AN_CLASS_MULTI);
      if (commit)
        tmo_q <= '0;
      else if (tmo_q != TMO_MAX)
        tmo_q <= tmo_q + TW'(1);
    end
  end

  assign stale = (tmo_q == TMO_MAX);

  // Per-digit capture and frame completion; a commit never lands in the clear cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      digits      <= 16'h0;
      digit_valid <= 4'h0;
      blank       <= 4'h0;
      bad_pattern <= 4'h0;
      frame_valid <= 1'b0;
      value       <= 16'h0;
    end else begin
      frame_valid <= 1'b0;
      if (digit_valid == 4'hF) begin
        frame_valid <= 1'b1;
        value       <= digits;
        digit_valid <= 4'h0;
        bad_pattern <= 4'h0;
      end
      if (commit) begin
        digit_valid[digit_idx]           <= 1'b1;
        digits[{digit_idx, 2'b00} +: 4]  <= dec_nibble;
        blank[digit_idx]                 <= dec_blank;
        bad_pattern[digit_idx]           <= ~dec_known & ~dec_blank;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_readback.sv
// tb/tb_sevenseg_readback.sv - scoreboard bench for the 7-segment readback block
module tb_sevenseg_readback;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] nib;
    logic       blank;
    logic       bad;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic [3:0]  bad_pattern;
  logic        frame_valid;
  logic [15:0] value;
  logic        multi_an;
  logic        stale;

  int checks = 0;
  int errors = 0;
  int frame_pulses = 0;
  int multi_pulses = 0;
  logic [15:0] frame_obs[$];
  logic [15:0] exp_frame_q[$];
  exp_t        exp_q[$];

  sevenseg_readback #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .blank       (blank),
    .bad_pattern (bad_pattern),
    .frame_valid (frame_valid),
    .value       (value),
    .multi_an    (multi_an),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  // One clock step; outputs are observed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) begin
      frame_pulses++;
      frame_obs.push_back(value);
    end
    if (multi_an === 1'b1) multi_pulses++;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    tick();
    tick();
    reset = 1'b0;
    frame_pulses = 0;
    multi_pulses = 0;
    frame_obs.delete();
    exp_frame_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({digits, digit_valid, blank, bad_pattern, frame_valid, value, multi_an, stale} !== 63'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {digits, digit_valid, blank, bad_pattern, frame_valid, value, multi_an, stale});
    end
  endtask

  task automatic test_single_commit();
    exp_t e;
    do_reset();
    exp_q.push_back('{idx: 2'd0, nib: 4'h2, blank: 1'b0, bad: 1'b0});
    drive(4'b1110, 7'h24, 16);
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_early got %b required 0000", digit_valid);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({digit_valid, digits[int'(e.idx)*4 +: 4], blank[e.idx], bad_pattern[e.idx]} !==
        {4'b0001, e.nib, e.blank, e.bad}) begin
      errors++;
      $display("FAIL single_commit got v=%b n=%h b=%b x=%b required v=0001 n=%h b=%b x=%b",
               digit_valid, digits[int'(e.idx)*4 +: 4], blank[e.idx], bad_pattern[e.idx],
               e.nib, e.blank, e.bad);
    end
  endtask

  task automatic test_frame();
    logic [15:0] ef, of;
    do_reset();
    exp_frame_q.push_back(16'h4321);
    drive(4'b1110, 7'h79, 20);
    drive(4'b1101, 7'h24, 20);
    drive(4'b1011, 7'h30, 20);
    drive(4'b0111, 7'h19, 20);
    checks++;
    if (frame_pulses !== 1) begin
      errors++;
      $display("FAIL frame_pulses got %0d required 1", frame_pulses);
    end
    ef = exp_frame_q.pop_front();
    of = (frame_obs.size() > 0) ? frame_obs.pop_front() : 16'hxxxx;
    checks++;
    if (of !== ef) begin
      errors++;
      $display("FAIL frame_value_at_pulse got %h required %h", of, ef);
    end
    checks++;
    if (value !== ef) begin
      errors++;
      $display("FAIL frame_value_held got %h required %h", value, ef);
    end
    checks++;
    if (digit_valid !== 4'b0000 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_clear got v=%b f=%b required v=0000 f=0", digit_valid, frame_valid);
    end
  endtask

  task automatic test_dwell_boundary();
    exp_t e;
    do_reset();
    drive(4'b1101, 7'h30, 15);
    exp_q.push_back('{idx: 2'd1, nib: 4'h5, blank: 1'b0, bad: 1'b0});
    drive(4'b1101, 7'h12, 16);
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL dwell15_commit got %b required 0000", digit_valid);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({digit_valid, digits[int'(e.idx)*4 +: 4], blank[e.idx], bad_pattern[e.idx]} !==
        {4'b0010, e.nib, e.blank, e.bad}) begin
      errors++;
      $display("FAIL dwell16_commit got v=%b n=%h required v=0010 n=%h",
               digit_valid, digits[int'(e.idx)*4 +: 4], e.nib);
    end
  endtask

  task automatic test_multi_an();
    exp_t e;
    do_reset();
    drive(4'b1110, 7'h40, 8);
    drive(4'b1100, 7'h40, 1);
    exp_q.push_back('{idx: 2'd0, nib: 4'h0, blank: 1'b0, bad: 1'b0});
    drive(4'b1110, 7'h40, 16);
    checks++;
    if (multi_pulses !== 1) begin
      errors++;
      $display("FAIL multi_an_pulses got %0d required 1", multi_pulses);
    end
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL multi_an_restart got %b required 0000", digit_valid);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({digit_valid, digits[int'(e.idx)*4 +: 4]} !== {4'b0001, e.nib}) begin
      errors++;
      $display("FAIL multi_an_recommit got v=%b n=%h required v=0001 n=%h",
               digit_valid, digits[int'(e.idx)*4 +: 4], e.nib);
    end
  endtask

  task automatic test_bad_pattern();
    exp_t e;
    logic [15:0] ef, of;
    do_reset();
    exp_frame_q.push_back(16'h00BF);
    exp_q.push_back('{idx: 2'd3, nib: 4'h0, blank: 1'b1, bad: 1'b0});
    exp_q.push_back('{idx: 2'd2, nib: 4'h0, blank: 1'b0, bad: 1'b1});
    drive(4'b0111, 7'h7F, 20);
    e = exp_q.pop_front();
    checks++;
    if ({digit_valid[e.idx], digits[int'(e.idx)*4 +: 4], blank[e.idx], bad_pattern[e.idx]} !==
        {1'b1, e.nib, e.blank, e.bad}) begin
      errors++;
      $display("FAIL blank_digit3 got v=%b n=%h b=%b x=%b required 1 %h %b %b",
               digit_valid[e.idx], digits[int'(e.idx)*4 +: 4], blank[e.idx], bad_pattern[e.idx],
               e.nib, e.blank, e.bad);
    end
    drive(4'b1011, 7'h55, 17);
    e = exp_q.pop_front();
    checks++;
    if ({bad_pattern, digits[int'(e.idx)*4 +: 4], blank[e.idx]} !== {4'b0100, e.nib, e.blank}) begin
      errors++;
      $display("FAIL bad_digit2 got x=%b n=%h b=%b required x=0100 n=%h b=%b",
               bad_pattern, digits[int'(e.idx)*4 +: 4], blank[e.idx], e.nib, e.blank);
    end
    drive(4'b1110, 7'h0E, 20);
    drive(4'b1101, 7'h03, 20);
    ef = exp_frame_q.pop_front();
    of = (frame_obs.size() > 0) ? frame_obs.pop_front() : 16'hxxxx;
    checks++;
    if (frame_pulses !== 1 || of !== ef) begin
      errors++;
      $display("FAIL bad_frame got pulses=%0d value=%h required pulses=1 value=%h",
               frame_pulses, of, ef);
    end
    checks++;
    if (bad_pattern !== 4'b0000 || blank !== 4'b1000) begin
      errors++;
      $display("FAIL bad_frame_flags got x=%b b=%b required x=0000 b=1000", bad_pattern, blank);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(4'hF, 7'h7F, 99);
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL stale_early got %b required 0", stale);
    end
    drive(4'hF, 7'h7F, 1);
    checks++;
    if (stale !== 1'b1) begin
      errors++;
      $display("FAIL stale_set got %b required 1", stale);
    end
    drive(4'hF, 7'h7F, 5);
    drive(4'b1110, 7'h40, 16);
    checks++;
    if (stale !== 1'b1 || digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL stale_hold got s=%b v=%b required s=1 v=0000", stale, digit_valid);
    end
    tick();
    checks++;
    if (stale !== 1'b0 || digit_valid !== 4'b0001) begin
      errors++;
      $display("FAIL stale_drop got s=%b v=%b required s=0 v=0001", stale, digit_valid);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    drive(4'b1110, 7'h79, 20);
    drive(4'b1101, 7'h40, 10);
    do_reset();
    checks++;
    if ({digits, digit_valid, blank, bad_pattern, value} !== 52'h0) begin
      errors++;
      $display("FAIL midframe_reset got %h required 0", {digits, digit_valid, blank, bad_pattern, value});
    end
    drive(4'b1101, 7'h40, 16);
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midframe_dwell got %b required 0000", digit_valid);
    end
    tick();
    checks++;
    if (digit_valid !== 4'b0010 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL midframe_commit got v=%b d=%h required v=0010 d=0000", digit_valid, digits);
    end
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    test_reset();
    test_single_commit();
    test_frame();
    test_dwell_boundary();
    test_multi_an();
    test_bad_pattern();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
